// File: rtl/mult_arb_pkg.sv
// Shared widths and helpers for the multiplier-sharing arbiter.
package mult_arb_pkg;

  localparam int DATA_W = 16;
  localparam int PROD_W = 32;
  localparam int CNT_W  = 32;

  function automatic int next_ptr(input int g, input int n);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/ALM_SOA5.sv
// 16x16 approximate logarithmic multiplier: Mitchell log/antilog with the low
// 5 bits of the mantissa adder replaced by a set-one adder; result truncated.
module ALM_SOA5 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [3:0]  ka, kb;
  logic [9:0]  fa, fb;
  logic [10:0] hi;
  logic [4:0]  k;
  logic [15:0] m;

  always_comb begin
    ka = '0;
    kb = '0;
    for (int i = 0; i < 16; i++) begin
      if (a[i]) ka = 4'(i);
      if (b[i]) kb = 4'(i);
    end
    // upper 10 fraction bits after normalising the leading one to bit 15
    fa = 10'((a << (4'd15 - ka)) >> 5);
    fb = 10'((b << (4'd15 - kb)) >> 5);
    hi = {1'b0, fa} + {1'b0, fb};
    k  = {1'b0, ka} + {1'b0, kb} + {4'b0, hi[10]};
    m  = {1'b1, hi[9:0], 5'b11111};
    if (a == 16'd0 || b == 16'd0) p = '0;
    else                          p = 32'(({32'b0, m} << k) >> 15);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (modulo NREQ) wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    if (en && found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one ALM_SOA5 among NREQ requesters through a two-stage pipeline
// (operand register, product register) with round-robin arbitration.
module mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_x,
  input  logic [NREQ*DATA_W-1:0] req_y,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PROD_W-1:0]      rsp_p,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy,
  output logic [CNT_W-1:0]       op_count
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_x, s1_y;
  logic [IDW-1:0]    s1_id;
  logic [IDW-1:0]    ptr;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic              adv1, adv2, accept;
  logic [DATA_W-1:0] sel_x, sel_y;
  logic [PROD_W-1:0] alm_p;

  assign adv2 = !rsp_valid || rsp_ready;
  assign adv1 = !s1_valid || adv2;

  // gating with rst_n keeps req_ready low during the reset cycle
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (adv1 && rst_n),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign busy      = s1_valid | rsp_valid;

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_x = req_x[i*DATA_W +: DATA_W];
        sel_y = req_y[i*DATA_W +: DATA_W];
      end
    end
  end

  ALM_SOA5 u_mult (
    .a (s1_x),
    .b (s1_y),
    .p (alm_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_id     <= '0;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= '0;
      op_count  <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= accept;
        if (accept) begin
          s1_x  <= sel_x;
          s1_y  <= sel_y;
          s1_id <= grant_idx;
        end
      end
      if (accept) ptr <= IDW'(next_ptr(int'(grant_idx), NREQ));
      if (adv2) begin
        rsp_valid <= s1_valid;
        rsp_p     <= alm_p;
        rsp_id    <= s1_id;
      end
      if (rsp_valid && rsp_ready) op_count <= op_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: directed scenarios plus a randomized
// run against a queue-based reference model with its own ALM_SOA5 arithmetic.
module tb_mult_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [63:0]     req_x, req_y;
  logic            rsp_valid, rsp_ready;
  logic [31:0]     rsp_p;
  logic [IDW-1:0]  rsp_id;
  logic            busy;
  logic [31:0]     op_count;

  mult_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_p(rsp_p), .rsp_id(rsp_id), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] p; int id; } exp_t;
  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr, m_cnt, m_ops;

  // Mitchell-style log multiply, done in plain integer arithmetic
  function automatic logic [31:0] alm_model(input logic [15:0] x, input logic [15:0] y);
    int ka, kb, fa, fb, hi, f, k;
    longint m;
    if (x == 16'd0 || y == 16'd0) return 32'd0;
    ka = 0; kb = 0;
    for (int i = 0; i < 16; i++) begin
      if (x[i]) ka = i;
      if (y[i]) kb = i;
    end
    fa = (int'(x) - (1 << ka)) * (1 << (15 - ka));
    fb = (int'(y) - (1 << kb)) * (1 << (15 - kb));
    hi = fa / 32 + fb / 32;
    k  = ka + kb;
    if (hi >= 1024) begin k = k + 1; hi = hi - 1024; end
    f = hi * 32 + 31;
    m = (longint'(32768 + f) * (longint'(1) << k)) / 32768;
    return 32'(m);
  endfunction

  function automatic logic [3:0] exp_grant(input logic [3:0] v, input int p);
    int i;
    for (int k = 0; k < 4; k++) begin
      i = (p + k) % 4;
      if (v[i]) return 4'(1 << i);
    end
    return 4'd0;
  endfunction

  function automatic int lane_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic rand_operands();
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 7))
        0:       req_x[16*i +: 16] = 16'h0000;
        1:       req_x[16*i +: 16] = 16'hFFFF;
        default: req_x[16*i +: 16] = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       req_y[16*i +: 16] = 16'h0000;
        1:       req_y[16*i +: 16] = 16'hFFFF;
        default: req_y[16*i +: 16] = 16'($urandom);
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0; m_cnt = 0; m_ops = 0;
    q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b1;
    rand_operands();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready c=%0d got=%b exp=0000", c, req_ready); end
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid c=%0d got=%b exp=0", c, rsp_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy c=%0d got=%b exp=0", c, busy); end
      n_tests++; if (op_count !== 32'd0) begin n_fail++; $display("FAIL reset_op_count c=%0d got=%0d exp=0", c, op_count); end
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_x[32 +: 16] = 16'h0004; req_y[32 +: 16] = 16'h0010;
    #1;
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_accept got=%b exp=0100", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_rsp got=%b exp=0", rsp_valid); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
    @(negedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    n_tests++; if (rsp_p !== 32'h0000_0040) begin n_fail++; $display("FAIL single_rsp_p got=%h exp=00000040", rsp_p); end
    n_tests++; if (rsp_id !== 2'd2) begin n_fail++; $display("FAIL single_rsp_id got=%0d exp=2", rsp_id); end
    @(negedge clk); #1;
    n_tests++; if (op_count !== 32'd1) begin n_fail++; $display("FAIL single_op_count got=%0d exp=1", op_count); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    int idc[4];
    logic [3:0] eg;
    do_reset();
    for (int i = 0; i < 4; i++) idc[i] = 0;
    for (int c = 0; c <= 10; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      rand_operands();
      #1;
      eg = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      n_tests++; if (req_ready !== eg) begin n_fail++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, eg); end
      if (c < 8) q.push_back('{alm_model(req_x[16*(c%4) +: 16], req_y[16*(c%4) +: 16]), c % 4});
      n_tests++; if (rsp_valid !== (c >= 2 && c <= 9)) begin n_fail++; $display("FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, (c >= 2 && c <= 9)); end
      if (rsp_valid === 1'b1 && q.size() > 0) begin
        n_tests++; if (rsp_id !== 2'(q[0].id) || rsp_p !== q[0].p) begin n_fail++; $display("FAIL rr_rsp c=%0d got=%0d/%h exp=%0d/%h", c, rsp_id, rsp_p, q[0].id, q[0].p); end
        idc[rsp_id]++;
        void'(q.pop_front());
      end
      if (c == 10) begin
        n_tests++; if (op_count !== 32'd8) begin n_fail++; $display("FAIL rr_op_count got=%0d exp=8", op_count); end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (idc[i] != 2) begin n_fail++; $display("FAIL rr_id_count id=%0d got=%0d exp=2", i, idc[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  eg;
    logic [31:0] pp;
    logic [1:0]  pid;
    do_reset();
    pp = '0; pid = '0;
    for (int c = 0; c <= 10; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      rsp_ready = (c < 3 || c >= 8);
      rand_operands();
      #1;
      eg = (c < 3) ? 4'(1 << c) : 4'b0000;
      n_tests++; if (req_ready !== eg) begin n_fail++; $display("FAIL bp_grant c=%0d got=%b exp=%b", c, req_ready, eg); end
      if (c < 3) q.push_back('{alm_model(req_x[16*c +: 16], req_y[16*c +: 16]), c});
      n_tests++; if (rsp_valid !== (c >= 2 && c <= 9)) begin n_fail++; $display("FAIL bp_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, (c >= 2 && c <= 9)); end
      if (c >= 4 && c <= 8) begin
        n_tests++; if (rsp_p !== pp || rsp_id !== pid) begin n_fail++; $display("FAIL bp_stable c=%0d got=%0d/%h exp=%0d/%h", c, rsp_id, rsp_p, pid, pp); end
      end
      if (rsp_valid === 1'b1 && q.size() > 0) begin
        n_tests++; if (rsp_id !== 2'(q[0].id) || rsp_p !== q[0].p) begin n_fail++; $display("FAIL bp_rsp c=%0d got=%0d/%h exp=%0d/%h", c, rsp_id, rsp_p, q[0].id, q[0].p); end
        if (rsp_ready) void'(q.pop_front());
      end
      pp = rsp_p; pid = rsp_id;
      if (c == 10) begin
        n_tests++; if (busy !== 1'b0 || op_count !== 32'd3) begin n_fail++; $display("FAIL bp_final got busy=%b cnt=%0d exp busy=0 cnt=3", busy, op_count); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_operands();
    logic [15:0] xs[24], ys[24];
    logic [31:0] ep;
    do_reset();
    xs[0] = 16'h0000; ys[0] = 16'hFFFF;
    xs[1] = 16'hFFFF; ys[1] = 16'hFFFF;
    xs[2] = 16'h0001; ys[2] = 16'h0001;
    xs[3] = 16'h8000; ys[3] = 16'h8000;
    for (int i = 4; i < 24; i++) begin xs[i] = 16'($urandom); ys[i] = 16'($urandom); end
    rsp_ready = 1'b1;
    for (int c = 0; c < 26; c++) begin
      req_valid = (c < 24) ? 4'b0001 : 4'b0000;
      if (c < 24) begin req_x[15:0] = xs[c]; req_y[15:0] = ys[c]; end
      #1;
      if (c < 24) begin
        n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL op_accept c=%0d got=%b exp=0001", c, req_ready); end
      end
      if (c >= 2) begin
        ep = alm_model(xs[c-2], ys[c-2]);
        n_tests++; if (rsp_valid !== 1'b1 || rsp_p !== ep || rsp_id !== 2'd0) begin n_fail++; $display("FAIL op_product c=%0d got=%b/%h/%0d exp=1/%h/0", c, rsp_valid, rsp_p, rsp_id, ep); end
      end
      if (c == 2) begin
        n_tests++; if (rsp_p !== 32'd0) begin n_fail++; $display("FAIL op_zero got=%h exp=00000000", rsp_p); end
      end
      if (c == 3) begin
        n_tests++; if (rsp_p !== 32'hFFDF_0000) begin n_fail++; $display("FAIL op_max got=%h exp=ffdf0000", rsp_p); end
      end
      if (c == 4) begin
        n_tests++; if (rsp_p !== 32'd1) begin n_fail++; $display("FAIL op_one got=%h exp=00000001", rsp_p); end
      end
      if (c == 5) begin
        n_tests++; if (rsp_p !== 32'h400F_8000) begin n_fail++; $display("FAIL op_pow2 got=%h exp=400f8000", rsp_p); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [3:0]  eg;
    logic        can, prev_hold;
    logic [31:0] pp;
    logic [1:0]  pid;
    int l;
    do_reset();
    prev_hold = 1'b0; pp = '0; pid = '0;
    for (int c = 0; c < 600; c++) begin
      if (c < 500) begin
        req_valid = 4'($urandom);
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        req_valid = '0;
        rsp_ready = 1'b1;
      end
      rand_operands();
      #1;
      can = (m_cnt < 2) || rsp_ready;
      eg  = can ? exp_grant(req_valid, m_ptr) : 4'b0000;
      n_tests++; if (req_ready !== eg) begin n_fail++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, req_ready, eg); end
      n_tests++; if (busy !== (m_cnt > 0)) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, (m_cnt > 0)); end
      if (prev_hold) begin
        n_tests++; if (rsp_valid !== 1'b1 || rsp_p !== pp || rsp_id !== pid) begin n_fail++; $display("FAIL rnd_stable c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, rsp_valid, rsp_id, rsp_p, pid, pp); end
      end
      if (rsp_valid === 1'b1) begin
        n_tests++;
        if (q.size() == 0) begin n_fail++; $display("FAIL rnd_spurious c=%0d got=%0d/%h exp=none", c, rsp_id, rsp_p); end
        else if (rsp_id !== 2'(q[0].id) || rsp_p !== q[0].p) begin n_fail++; $display("FAIL rnd_rsp c=%0d got=%0d/%h exp=%0d/%h", c, rsp_id, rsp_p, q[0].id, q[0].p); end
      end
      if (eg != 4'b0000) begin
        l = lane_of(eg);
        q.push_back('{alm_model(req_x[16*l +: 16], req_y[16*l +: 16]), l});
        m_ptr = (l + 1) % 4;
        m_cnt++;
      end
      if (rsp_valid === 1'b1 && rsp_ready && q.size() > 0) begin
        void'(q.pop_front());
        m_cnt--;
        m_ops++;
      end
      prev_hold = (rsp_valid === 1'b1) && !rsp_ready;
      pp = rsp_p; pid = rsp_id;
      @(negedge clk);
    end
    #1;
    n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_lost got=%0d pending exp=0", q.size()); end
    n_tests++; if (op_count !== 32'(m_ops)) begin n_fail++; $display("FAIL rnd_op_count got=%0d exp=%0d", op_count, m_ops); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ep;
    do_reset();
    rsp_ready = 1'b0; req_valid = 4'b1111;
    rand_operands();
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_full got=%b/%b exp=1/0000", rsp_valid, req_ready); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 4'b1000;
    req_x[48 +: 16] = 16'($urandom); req_y[48 +: 16] = 16'($urandom);
    ep = alm_model(req_x[48 +: 16], req_y[48 +: 16]);
    #1;
    n_tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_flush got=%b/%b exp=0/0", rsp_valid, busy); end
    n_tests++; if (dut.ptr !== 2'd0) begin n_fail++; $display("FAIL mid_ptr got=%0d exp=0", dut.ptr); end
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL mid_accept got=%b exp=1000", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale got=%b exp=0", rsp_valid); end
    @(negedge clk); #1;
    n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_p !== ep) begin n_fail++; $display("FAIL mid_rsp got=%b/%0d/%h exp=1/3/%h", rsp_valid, rsp_id, rsp_p, ep); end
    n_tests++; if (op_count !== 32'd0) begin n_fail++; $display("FAIL mid_op_count got=%0d exp=0", op_count); end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    do_reset();
    rsp_ready = 1'b0; req_valid = 4'b0001;
    req_x[15:0] = 16'd3; req_y[15:0] = 16'd5;
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    force dut.op_count = 32'hFFFF_FFFF;
    #1;
    release dut.op_count;
    n_tests++; if (op_count !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload got=%h exp=ffffffff", op_count); end
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_rsp_valid got=%b exp=1", rsp_valid); end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_tests++; if (op_count !== 32'd0) begin n_fail++; $display("FAIL wrap_op_count got=%h exp=00000000", op_count); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1; req_x = '0; req_y = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_operands();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
